// File: rtl/apb_txn_arbiter.sv
// Round-robin arbiter that shares one APB front-end between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort transfers that see no pready within TIMEOUT_CYCLES.
module apb_txn_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             err,
    output logic                             busy,
    output logic                             m_req,
    output logic                             m_pwrite,
    output logic [ADDR_WIDTH-1:0]            m_paddr,
    output logic [DATA_WIDTH-1:0]            m_pwdata,
    input  logic [DATA_WIDTH-1:0]            m_prdata,
    input  logic                             m_pready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || ADDR_WIDTH < 1 || ADDR_WIDTH > 32 ||
        DATA_WIDTH < 1 || DATA_WIDTH > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_txn_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Command latched from the winning requester and held for the whole transfer
    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   m_req_q, m_req_d;
    cmd_t                   cmd_q, cmd_d;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand;
    cmd_t                   sel_cmd;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

    // Round-robin search starting just above the previous winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_cmd = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                sel_cmd.write = req_write[k];
                sel_cmd.addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_cmd.wdata = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        busy_d  = busy_q;
        m_req_d = m_req_q;
        cmd_d   = cmd_q;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_XFER;
                    last_d  = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    cmd_d   = sel_cmd;
                    m_req_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_XFER: begin
                if (m_pready) begin
                    state_d = S_RESP;
                    done_d  = gnt_q;
                    err_d   = 1'b0;
                    m_req_d = 1'b0;
                    if (!cmd_q.write) begin
                        rdata_d = m_prdata;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RESP;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    m_req_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                done_d  = '0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= S_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            m_req_q <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            m_req_q <= m_req_d;
            cmd_q   <= cmd_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign m_req    = m_req_q;
    assign m_pwrite = cmd_q.write;
    assign m_paddr  = cmd_q.addr;
    assign m_pwdata = cmd_q.wdata;

endmodule
